// File: rtl/sort_arbiter_2_if.sv
// sort_arbiter_2_if
//   Bundles the request, sorter and response signals of sort_arbiter_2.
//   slave  : the arbiter's view (drives ready, sorter inputs, response, status).
//   master : the surrounding system's view (requesters plus the attached
//            4-input sorter).
//
//   en                      grant enable
//   req{0,1}_valid/_ready   request handshake, 4-element vectors in req{0,1}_data
//   s_x_valid/s_x/s_x_label sorter input side
//   s_y_valid/s_y/s_y_label sorter output side
//   rsp_valid/rsp_id/rsp_data/rsp_label  sorted result and its owner
//   busy, err, issued_cnt   status
interface sort_arbiter_2_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 2
);
    logic                     en;
    logic                     req0_valid;
    logic                     req1_valid;
    logic                     req0_ready;
    logic                     req1_ready;
    logic [4*DATA_WIDTH-1:0]  req0_data;
    logic [4*DATA_WIDTH-1:0]  req1_data;

    logic                     s_x_valid;
    logic [4*DATA_WIDTH-1:0]  s_x;
    logic [4*LABEL_WIDTH-1:0] s_x_label;
    logic                     s_y_valid;
    logic [4*DATA_WIDTH-1:0]  s_y;
    logic [4*LABEL_WIDTH-1:0] s_y_label;

    logic                     rsp_valid;
    logic                     rsp_id;
    logic [4*DATA_WIDTH-1:0]  rsp_data;
    logic [4*LABEL_WIDTH-1:0] rsp_label;

    logic                     busy;
    logic                     err;
    logic [15:0]              issued_cnt;

    modport slave (
        input  en, req0_valid, req1_valid, req0_data, req1_data,
               s_y_valid, s_y, s_y_label,
        output req0_ready, req1_ready,
               s_x_valid, s_x, s_x_label,
               rsp_valid, rsp_id, rsp_data, rsp_label,
               busy, err, issued_cnt
    );

    modport master (
        output en, req0_valid, req1_valid, req0_data, req1_data,
               s_y_valid, s_y, s_y_label,
        input  req0_ready, req1_ready,
               s_x_valid, s_x, s_x_label,
               rsp_valid, rsp_id, rsp_data, rsp_label,
               busy, err, issued_cnt
    );
endinterface

// File: rtl/sort_arbiter_2.sv
// sort_arbiter_2
//   Two-requester round-robin front end for a fixed-latency 4-input sorter.
//   A granted vector is registered onto the sorter input for one cycle with
//   slot labels 0..3; a {valid, id} tracker of LATENCY stages follows it so
//   the sorter's result can be tagged with its owner. A sticky err flag
//   records any cycle where the sorter output disagrees with the tracker.
//
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sort_arbiter_2_if.slave (request handshake, sorter ports,
//          response, busy/err/issued_cnt status)
module sort_arbiter_2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 2,
    parameter int LATENCY     = 3
) (
    input  logic             clk,
    input  logic             rst,
    sort_arbiter_2_if.slave  bus
);

    logic                     grant0;
    logic                     grant1;
    logic                     any_grant;
    logic [4*LABEL_WIDTH-1:0] slot_labels;

    logic                     ptr;        // favoured requester
    logic                     x_valid_q;
    logic [4*DATA_WIDTH-1:0]  x_q;
    logic [4*LABEL_WIDTH-1:0] x_label_q;
    logic                     x_id_q;
    logic [LATENCY-1:0]       trk_valid;
    logic [LATENCY-1:0]       trk_id;
    logic                     err_q;
    logic [15:0]              cnt_q;

    // Grant is combinational so a request is accepted in the cycle it is
    // presented. The favoured requester wins a tie; a lone requester always wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && bus.en) begin
            if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign any_grant = grant0 | grant1;

    // Slot i of the sorter input always carries label i.
    always_comb begin
        slot_labels = '0;
        for (int i = 0; i < 4; i++) begin
            slot_labels[i*LABEL_WIDTH +: LABEL_WIDTH] = LABEL_WIDTH'(i);
        end
    end

    // Issue stage: the accepted vector sits on the sorter input for exactly
    // one cycle; data and labels hold their last values otherwise.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state registers use non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            ptr       <= 1'b0;
            x_valid_q <= 1'b0;
            x_q       <= '0;
            x_label_q <= '0;
            x_id_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            x_valid_q <= any_grant;
            if (any_grant) begin
                x_q       <= grant1 ? bus.req1_data : bus.req0_data;
                x_label_q <= slot_labels;
                x_id_q    <= grant1;
                ptr       <= grant0;       // favour the one just passed over
                cnt_q     <= cnt_q + 16'd1;
            end
        end
    end

    // Tracker: mirrors the sorter pipeline. Stage 0 loads on the same edge
    // the sorter samples s_x, so the last stage lines up with s_y_valid.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every tracker stage is reset (unlike a plain data store)
        // because the valid bits decide err; a mid-flight reset must empty it.
        if (!rst) begin
            trk_valid <= '0;
            trk_id    <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_id[i]    <= trk_id[i-1];
            end
            trk_valid[0] <= x_valid_q;
            trk_id[0]    <= x_id_q;
            if (bus.s_y_valid != trk_valid[LATENCY-1]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.s_x_valid  = x_valid_q;
    assign bus.s_x        = x_q;
    assign bus.s_x_label  = x_label_q;
    assign bus.rsp_valid  = bus.s_y_valid;
    assign bus.rsp_id     = trk_id[LATENCY-1];
    assign bus.rsp_data   = bus.s_y;
    assign bus.rsp_label  = bus.s_y_label;
    assign bus.busy       = x_valid_q | (|trk_valid);
    assign bus.err        = err_q;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: doc/sort_arbiter_2.md
SORT_ARBITER_2 -- requirements
Module: sort_arbiter_2

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, the width of one sort element.
REQ-002 The module SHALL have parameter LABEL_WIDTH, default 2, the label width; it SHALL be at least 2.
REQ-003 The module SHALL have parameter LATENCY, default 3, the fixed x_valid-to-y_valid pipeline depth of the attached 4-input sorter; it SHALL be at least 1.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port en, input, 1 bit: grant enable; when low, no new requests are accepted.
REQ-007 The module SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester has a 4-element vector pending.
REQ-008 The module SHALL have ports req0_ready and req1_ready, output, 1 bit each: request accepted this cycle.
REQ-009 The module SHALL have ports req0_data and req1_data, input, 4*DATA_WIDTH each: element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The module SHALL have port s_x_valid, output, 1 bit: drives the sorter x_valid.
REQ-011 The module SHALL have port s_x, output, 4*DATA_WIDTH: drives sorter x_0..x_3, packed as in REQ-009.
REQ-012 The module SHALL have port s_x_label, output, 4*LABEL_WIDTH: drives sorter x_label_0..3.
REQ-013 The module SHALL have port s_y_valid, input, 1 bit: the sorter y_valid.
REQ-014 The module SHALL have port s_y, input, 4*DATA_WIDTH: sorter y_0..y_3.
REQ-015 The module SHALL have port s_y_label, input, 4*LABEL_WIDTH: sorter y_label_0..3.
REQ-016 The module SHALL have port rsp_valid, output, 1 bit: sorted result present.
REQ-017 The module SHALL have port rsp_id, output, 1 bit: the requester that owns the result.
REQ-018 The module SHALL have port rsp_data, output, 4*DATA_WIDTH: equal to s_y.
REQ-019 The module SHALL have port rsp_label, output, 4*LABEL_WIDTH: equal to s_y_label.
REQ-020 The module SHALL have port busy, output, 1 bit: at least one vector is in flight (s_x_valid or any tracker stage valid).
REQ-021 The module SHALL have port err, output, 1 bit: sticky tracker/sorter mismatch flag.
REQ-022 The module SHALL have port issued_cnt, output, 16 bits: count of accepted requests.

Function
REQ-023 Grant SHALL be combinational; at most one of req0_ready/req1_ready SHALL be high in any cycle, and only when en=1 and the matching valid is 1.
REQ-024 Round-robin: a 1-bit pointer (reset 0) names the favoured requester; if both are valid, the favoured one SHALL be granted; if only one is valid, it SHALL be granted.
REQ-025 After any grant, the pointer SHALL be set to the non-granted requester; with no grant, the pointer SHALL hold.
REQ-026 On accept at edge k, s_x_valid SHALL be 1 for exactly the following cycle, with s_x = the accepted data and s_x_label slot i = i (zero-extended).
REQ-027 When s_x_valid=0, s_x and s_x_label SHALL hold their last values.
REQ-028 Tracker: a LATENCY-stage shift register of {valid, id} SHALL shift every cycle; stage 0 loads {s_x_valid, granted id} on the same edge the sorter samples s_x.
REQ-029 rsp_valid SHALL equal s_y_valid, and rsp_id SHALL equal the id in the last tracker stage, both combinationally.
REQ-030 err SHALL be set at any edge where s_y_valid differs from the last tracker stage valid, and SHALL stay set until reset.
REQ-031 issued_cnt SHALL increment by 1 per accept, wrapping from 0xFFFF to 0x0000.
REQ-032 Back-to-back accepts every cycle SHALL be supported, with no bubbles.
REQ-033 When en drops low, in-flight vectors SHALL complete normally, and busy SHALL fall LATENCY+1 cycles after the last accept.

Reset
REQ-034 While rst=0: s_x_valid, s_x, s_x_label, all tracker stages, the pointer, err and issued_cnt SHALL be 0, and req0_ready/req1_ready SHALL be 0.
REQ-035 Reset asserted mid-flight SHALL discard all in-flight vectors; sorter output arriving after reset SHALL set err.

Verification
REQ-036 Single request: with the real sorter (SIGNED=1, ASCENDING=0, LATENCY=3), req0_data elements {0x05,0x80,0x7F,0x00} -> ready in the same cycle, rsp 4 cycles later with rsp_id=0, data {0x7F,0x05,0x00,0x80}, labels {2,0,3,1}.
REQ-037 Contention: both valid for 4 cycles after reset -> grants in order 0,1,0,1; rsp_id sequence 0,1,0,1 on consecutive cycles; issued_cnt=4.
REQ-038 Single requester streaming: req1 valid for 10 cycles while req0 is idle -> 10 consecutive grants to req1; the pointer ends at 0.
REQ-039 Enable gating: en=0 with both valid -> no ready; set en=1 -> the grant resumes from the held pointer; busy falls 4 cycles after the last accept.
REQ-040 Faults: inject s_y_valid with the tracker empty -> err=1 and stays 1; reset pulsed during flight -> all outputs 0, no rsp_valid from the tracker.
REQ-041 Counter wrap: preload by 65535 accepts, then one more -> issued_cnt=0x0000.
